// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button conditioner channels.
package btn_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ON   = 2'd1,
        S_HELD = 2'd2,
        S_REL  = 2'd3
    } btn_state_e;

    // Width needed to hold the largest terminal count without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One input channel: synchroniser, debounce FSM, press/release pulses and optional auto-repeat.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic out,
    output logic rel
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DEB_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    btn_state_e             ps, ns;
    logic [CW-1:0]          dcnt_q, dcnt_d;
    logic                   press_accept, rel_accept, rep_hit;

    // Normalise so that 1 always means pressed; reset loads the released value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in ^ (ACTIVE_LOW != 0);
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    assign press_accept = (ps == S_OFF) && s && (dcnt_q == DEB_TERM);
    assign rel_accept   = (ps == S_HELD) && !s && (dcnt_q == DEB_TERM);

    always_comb begin
        ns     = ps;
        dcnt_d = '0;
        case (ps)
            S_OFF: begin
                if (press_accept) ns = S_ON;
                else if (s)       dcnt_d = dcnt_q + 1'b1;
            end
            S_ON:  ns = S_HELD;
            S_HELD: begin
                if (rel_accept) ns = S_REL;
                else if (!s)    dcnt_d = dcnt_q + 1'b1;
            end
            S_REL:   ns = S_OFF;
            default: ns = S_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps     <= S_OFF;
            dcnt_q <= '0;
        end else begin
            ps     <= ns;
            dcnt_q <= dcnt_d;
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rep
            localparam logic [CW-1:0] DELAY_TERM  = CW'(REPEAT_DELAY - 1);
            localparam logic [CW-1:0] PERIOD_TERM = CW'(REPEAT_PERIOD - 1);

            logic [CW-1:0] rcnt_q;
            logic          first_q;
            logic [CW-1:0] rep_term;

            assign rep_term = first_q ? DELAY_TERM : PERIOD_TERM;
            // A release accepted in the same cycle suppresses the repeat pulse.
            assign rep_hit  = (ps == S_HELD) && (rcnt_q == rep_term) && !rel_accept;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rcnt_q  <= '0;
                    first_q <= 1'b0;
                end else if (ps == S_ON) begin
                    rcnt_q  <= '0;
                    first_q <= 1'b1;
                end else if (ps == S_HELD) begin
                    if (rcnt_q == rep_term) begin
                        rcnt_q  <= '0;
                        first_q <= 1'b0;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
            end
        end else begin : g_no_rep
            assign rep_hit = 1'b0;
        end
    endgenerate

    assign level = (ps == S_ON) || (ps == S_HELD);
    assign out   = (ps == S_ON) || rep_hit;
    assign rel   = (ps == S_REL);

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel key/switch front end: N_CH independent conditioned channels plus an any-press flag.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] rel,
    output logic            any_out
);

    generate
        for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
            btn_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .ACTIVE_LOW     (ACTIVE_LOW),
                .REPEAT_EN      (REPEAT_EN),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_ch (
                .clk  (clk),
                .reset(reset),
                .in   (in[i]),
                .level(level[i]),
                .out  (out[i]),
                .rel  (rel[i])
            );
        end
    endgenerate

    assign any_out = |out;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: default, auto-repeat and minimal-latency configurations.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0] in0, lvl0, out0, rel0;
    logic       any0;
    logic [3:0] in1, lvl1, out1, rel1;
    logic       any1;
    logic [3:0] in2, lvl2, out2, rel2;
    logic       any2;

    button_conditioner #(.N_CH(4)) u_dut0 (
        .clk(clk), .reset(reset), .in(in0), .level(lvl0), .out(out0), .rel(rel0), .any_out(any0)
    );

    button_conditioner #(
        .N_CH(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) u_dut1 (
        .clk(clk), .reset(reset), .in(in1), .level(lvl1), .out(out1), .rel(rel1), .any_out(any1)
    );

    button_conditioner #(
        .N_CH(4), .SYNC_STAGES(1), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(0)
    ) u_dut2 (
        .clk(clk), .reset(reset), .in(in2), .level(lvl2), .out(out2), .rel(rel2), .any_out(any2)
    );

    typedef struct {
        logic [3:0] in;
        int         n;
        logic [3:0] lvl;
        logic [3:0] out;
        logic [3:0] rel;
        logic       any;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    initial begin
        // in, cycles to advance, expected level/out/release/any after the last cycle
        vecs.push_back('{4'hF, 5, 4'h0, 4'h0, 4'h0, 1'b0});   // idle after reset
        vecs.push_back('{4'hE, 5, 4'h0, 4'h0, 4'h0, 1'b0});   // ch0 press, still debouncing
        vecs.push_back('{4'hE, 1, 4'h1, 4'h1, 4'h0, 1'b1});   // press pulse at +6
        vecs.push_back('{4'hE, 1, 4'h1, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{4'hE, 10, 4'h1, 4'h0, 4'h0, 1'b0});  // held, no repeat
        vecs.push_back('{4'hF, 5, 4'h1, 4'h0, 4'h0, 1'b0});   // release debouncing
        vecs.push_back('{4'hF, 1, 4'h0, 4'h0, 4'h1, 1'b0});   // release pulse at +6
        vecs.push_back('{4'hF, 1, 4'h0, 4'h0, 4'h0, 1'b0});
        for (int k = 0; k < 5; k++) begin                      // ch1 bouncing every 2 cycles
            vecs.push_back('{4'hD, 2, 4'h0, 4'h0, 4'h0, 1'b0});
            vecs.push_back('{4'hF, 2, 4'h0, 4'h0, 4'h0, 1'b0});
        end
        vecs.push_back('{4'hF, 8, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{4'h5, 5, 4'h0, 4'h0, 4'h0, 1'b0});   // ch1 and ch3 together
        vecs.push_back('{4'h5, 1, 4'hA, 4'hA, 4'h0, 1'b1});
        vecs.push_back('{4'h5, 1, 4'hA, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{4'h5, 4, 4'hA, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{4'hF, 5, 4'hA, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{4'hF, 1, 4'h0, 4'h0, 4'hA, 1'b0});
        vecs.push_back('{4'hF, 1, 4'h0, 4'h0, 4'h0, 1'b0});

        reset = 1'b1;
        in0   = 4'hF;
        in1   = 4'hF;
        in2   = 4'h0;
        repeat (3) step();
        reset = 1'b0;

        check("reset_level1", {28'd0, lvl1}, 32'd0);
        check("reset_out2", {28'd0, out2}, 32'd0);

        foreach (vecs[i]) begin
            in0 = vecs[i].in;
            repeat (vecs[i].n) step();
            check($sformatf("vec%0d_level", i), {28'd0, lvl0}, {28'd0, vecs[i].lvl});
            check($sformatf("vec%0d_out", i), {28'd0, out0}, {28'd0, vecs[i].out});
            check($sformatf("vec%0d_rel", i), {28'd0, rel0}, {28'd0, vecs[i].rel});
            check($sformatf("vec%0d_any", i), {31'd0, any0}, {31'd0, vecs[i].any});
        end

        // Auto-repeat on ch2: press at 6, repeats at 16 then every 5; release accepted at 41.
        in1 = 4'hB;
        for (int c = 1; c <= 50; c++) begin
            logic exp_out;
            step();
            exp_out = (c == 6) || (c == 16) || (c == 21) || (c == 26) || (c == 31) || (c == 36);
            check($sformatf("rep_out_c%0d", c), {28'd0, out1}, {28'd0, exp_out, 2'b00});
            check($sformatf("rep_any_c%0d", c), {31'd0, any1}, {31'd0, exp_out});
            check($sformatf("rep_level_c%0d", c), {28'd0, lvl1},
                  {28'd0, 1'b0, (c >= 6 && c <= 41), 2'b00});
            check($sformatf("rep_rel_c%0d", c), {28'd0, rel1}, {28'd0, 1'b0, (c == 42), 2'b00});
            if (c == 36) in1 = 4'hF;
        end

        // Minimal config: 3-cycle high pulse on ch0, active-high, no repeat.
        in2 = 4'h1;
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("min_out_c%0d", c), {28'd0, out2}, {31'd0, (c == 2)});
            check($sformatf("min_level_c%0d", c), {28'd0, lvl2}, {31'd0, (c >= 2 && c <= 4)});
            check($sformatf("min_rel_c%0d", c), {28'd0, rel2}, {31'd0, (c == 5)});
            if (c == 3) in2 = 4'h0;
        end

        // Reset while ch0 is held: level drops, then a fresh press pulse after full debounce.
        in0 = 4'hE;
        repeat (6) step();
        check("rst_hold_level", {28'd0, lvl0}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_level_cleared", {28'd0, lvl0}, 32'd0);
        check("rst_out_cleared", {28'd0, out0}, 32'd0);
        repeat (5) step();
        check("rst_no_early_out", {28'd0, out0}, 32'd0);
        step();
        check("rst_repress_out", {28'd0, out0}, 32'd1);
        check("rst_repress_any", {31'd0, any0}, 32'd1);
        step();
        check("rst_repress_single", {28'd0, out0}, 32'd0);
        in0 = 4'hF;
        repeat (8) step();
        check("rst_final_idle", {28'd0, lvl0}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
